// File: rtl/mac_pause_ctrl_tx_sched.sv
// Transmit-side pause scheduler.
// Turns local LFC/PFC congestion requests into MAC control frame requests.
// An XOFF is sent when a request asserts and an XON when it releases. While a
// request stays asserted, XOFFs are re-sent at the refresh interval. Only one
// frame is outstanding at a time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tx_lfc_en/req         local LFC enable and request
//   tx_pfc_en/req [7:0]   per-class local PFC enable and request
//   mcf_valid/ready       handshake towards the TX MCF generator
//   mcf_eth_*/opcode      frame header fields (registered at launch)
//   mcf_params            frame parameters, byte 0 in bits [7:0]
//   cfg_*                 header, opcode, quanta, refresh and tick configuration
//   stat_tx_*             one-cycle pulses when a frame is accepted
module mac_pause_ctrl_tx_sched #(
    parameter int unsigned MCF_PARAMS_SIZE = 18,
    parameter bit          PFC_EN          = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tx_lfc_en,
    input  logic                         tx_lfc_req,
    input  logic [7:0]                   tx_pfc_en,
    input  logic [7:0]                   tx_pfc_req,
    output logic                         mcf_valid,
    input  logic                         mcf_ready,
    output logic [47:0]                  mcf_eth_dst,
    output logic [47:0]                  mcf_eth_src,
    output logic [15:0]                  mcf_eth_type,
    output logic [15:0]                  mcf_opcode,
    output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
    input  logic [47:0]                  cfg_mcf_eth_dst,
    input  logic [47:0]                  cfg_mcf_eth_src,
    input  logic [15:0]                  cfg_mcf_eth_type,
    input  logic [15:0]                  cfg_tx_lfc_opcode,
    input  logic                         cfg_tx_lfc_en,
    input  logic [15:0]                  cfg_tx_lfc_quanta,
    input  logic [15:0]                  cfg_tx_lfc_refresh,
    input  logic [15:0]                  cfg_tx_pfc_opcode,
    input  logic                         cfg_tx_pfc_en,
    input  logic [15:0]                  cfg_tx_pfc_quanta,
    input  logic [15:0]                  cfg_tx_pfc_refresh,
    input  logic [9:0]                   cfg_quanta_step,
    input  logic                         cfg_quanta_clk_en,
    output logic                         stat_tx_lfc_pkt,
    output logic                         stat_tx_lfc_xon,
    output logic                         stat_tx_lfc_xoff,
    output logic                         stat_tx_pfc_pkt,
    output logic [7:0]                   stat_tx_pfc_xon,
    output logic [7:0]                   stat_tx_pfc_xoff
);

    localparam int unsigned PW      = MCF_PARAMS_SIZE * 8;
    localparam int unsigned NCLS    = 8;
    localparam int unsigned PFC_PW  = 16 + 16 * NCLS;

    // Parameter field too small for the frame types that can be generated
    if (PFC_EN ? (MCF_PARAMS_SIZE < 18) : (MCF_PARAMS_SIZE < 2)) begin : g_bad_params_size
        $fatal(1, "mac_pause_ctrl_tx_sched: MCF_PARAMS_SIZE too small");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LFC_TX = 2'd1,
        PFC_TX = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          acc;
    logic [1:0]          inc;
    logic                lfc_eff_d;
    logic [NCLS-1:0]     pfc_eff_d;
    logic                lfc_pend;
    logic [NCLS-1:0]     pfc_pend;
    logic [15:0]         lfc_ref_cnt;
    logic [15:0]         pfc_ref_cnt [NCLS];
    logic                lfc_xoff_sent;
    logic [NCLS-1:0]     pfc_sel;
    logic [NCLS-1:0]     pfc_xoff_sent;

    logic [9:0]          quanta_sum_c;
    logic                lfc_eff_c;
    logic [NCLS-1:0]     pfc_eff_c;
    logic                pfc_en_c;
    logic                accept_c;
    logic                lfc_ref_hit_c;
    logic [NCLS-1:0]     pfc_ref_hit_c;
    logic                lfc_set_c;
    logic [NCLS-1:0]     pfc_set_c;
    logic                lfc_go_c;
    logic                pfc_go_c;
    logic                lfc_pend_nxt_c;
    logic [NCLS-1:0]     pfc_pend_nxt_c;
    logic                lfc_xoff_c;
    logic [NCLS-1:0]     pfc_xoff_c;
    logic [15:0]         lfc_params_c;
    logic [PFC_PW-1:0]   pfc_params_c;
    logic                lfc_reload_c;
    logic [NCLS-1:0]     pfc_reload_c;

    function automatic logic [15:0] sat_dec(input logic [15:0] cnt, input logic [1:0] step);
        sat_dec = (cnt > 16'(step)) ? (cnt - 16'(step)) : 16'h0000;
    endfunction

    // Request qualification, pending-bit updates and launch decisions
    always_comb begin
        quanta_sum_c  = {2'b00, acc} + cfg_quanta_step;
        lfc_eff_c     = tx_lfc_req & tx_lfc_en;
        pfc_eff_c     = PFC_EN ? (tx_pfc_req & tx_pfc_en) : '0;
        pfc_en_c      = cfg_tx_pfc_en & PFC_EN;
        accept_c      = mcf_valid & mcf_ready;

        // A class already queued or on the wire does not need a refresh
        lfc_ref_hit_c = (lfc_ref_cnt == 16'h0000) && lfc_eff_c && (cfg_tx_lfc_refresh != 16'h0000)
                        && !lfc_pend && (state != LFC_TX);
        for (int k = 0; k < NCLS; k++) begin
            pfc_ref_hit_c[k] = (pfc_ref_cnt[k] == 16'h0000) && pfc_eff_c[k]
                               && (cfg_tx_pfc_refresh != 16'h0000) && !pfc_pend[k]
                               && !((state == PFC_TX) && pfc_sel[k]);
        end

        lfc_set_c = (lfc_eff_c != lfc_eff_d) || lfc_ref_hit_c;
        pfc_set_c = (pfc_eff_c ^ pfc_eff_d) | pfc_ref_hit_c;

        lfc_go_c  = (state == IDLE) && lfc_pend && cfg_tx_lfc_en;
        pfc_go_c  = (state == IDLE) && !lfc_go_c && (pfc_pend != '0) && pfc_en_c;

        // New events win over the launch clear so a late change is not lost
        lfc_pend_nxt_c = cfg_tx_lfc_en && (lfc_set_c || (lfc_pend && !lfc_go_c));
        pfc_pend_nxt_c = !pfc_en_c ? '0 : (pfc_go_c ? pfc_set_c : (pfc_set_c | pfc_pend));

        lfc_xoff_c   = lfc_eff_c && (cfg_tx_lfc_quanta != 16'h0000);
        lfc_params_c = lfc_eff_c ? {cfg_tx_lfc_quanta[7:0], cfg_tx_lfc_quanta[15:8]} : 16'h0000;

        // PFC body: zero byte, class-enable vector, then one byte-swapped quanta per class
        pfc_params_c       = '0;
        pfc_params_c[15:8] = pfc_pend;
        for (int k = 0; k < NCLS; k++) begin
            pfc_xoff_c[k] = pfc_pend[k] && pfc_eff_c[k] && (cfg_tx_pfc_quanta != 16'h0000);
            if (pfc_pend[k] && pfc_eff_c[k]) begin
                pfc_params_c[16 + 16 * k +: 16] = {cfg_tx_pfc_quanta[7:0], cfg_tx_pfc_quanta[15:8]};
            end
        end

        lfc_reload_c = (state == LFC_TX) && accept_c && lfc_xoff_sent;
        pfc_reload_c = ((state == PFC_TX) && accept_c) ? (pfc_sel & pfc_xoff_sent) : '0;
    end

    // State, counters, frame fields and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            acc              <= '0;
            inc              <= '0;
            lfc_eff_d        <= 1'b0;
            pfc_eff_d        <= '0;
            lfc_pend         <= 1'b0;
            pfc_pend         <= '0;
            lfc_ref_cnt      <= '0;
            for (int k = 0; k < NCLS; k++) begin
                pfc_ref_cnt[k] <= '0;
            end
            lfc_xoff_sent    <= 1'b0;
            pfc_sel          <= '0;
            pfc_xoff_sent    <= '0;
            mcf_valid        <= 1'b0;
            mcf_eth_dst      <= '0;
            mcf_eth_src      <= '0;
            mcf_eth_type     <= '0;
            mcf_opcode       <= '0;
            mcf_params       <= '0;
            stat_tx_lfc_pkt  <= 1'b0;
            stat_tx_lfc_xon  <= 1'b0;
            stat_tx_lfc_xoff <= 1'b0;
            stat_tx_pfc_pkt  <= 1'b0;
            stat_tx_pfc_xon  <= '0;
            stat_tx_pfc_xoff <= '0;
        end else begin
            stat_tx_lfc_pkt  <= 1'b0;
            stat_tx_lfc_xon  <= 1'b0;
            stat_tx_lfc_xoff <= 1'b0;
            stat_tx_pfc_pkt  <= 1'b0;
            stat_tx_pfc_xon  <= '0;
            stat_tx_pfc_xoff <= '0;

            // Fractional quanta accumulator: carry-out is the per-cycle quanta tick
            if (cfg_quanta_clk_en) begin
                acc <= quanta_sum_c[7:0];
                inc <= quanta_sum_c[9:8];
            end else begin
                inc <= 2'd0;
            end

            lfc_eff_d <= lfc_eff_c;
            pfc_eff_d <= pfc_eff_c;
            lfc_pend  <= lfc_pend_nxt_c;
            pfc_pend  <= pfc_pend_nxt_c;

            lfc_ref_cnt <= lfc_reload_c ? cfg_tx_lfc_refresh : sat_dec(lfc_ref_cnt, inc);
            for (int k = 0; k < NCLS; k++) begin
                pfc_ref_cnt[k] <= pfc_reload_c[k] ? cfg_tx_pfc_refresh : sat_dec(pfc_ref_cnt[k], inc);
            end

            case (state)
                IDLE: begin
                    if (lfc_go_c) begin
                        state         <= LFC_TX;
                        mcf_valid     <= 1'b1;
                        mcf_eth_dst   <= cfg_mcf_eth_dst;
                        mcf_eth_src   <= cfg_mcf_eth_src;
                        mcf_eth_type  <= cfg_mcf_eth_type;
                        mcf_opcode    <= cfg_tx_lfc_opcode;
                        mcf_params    <= PW'(lfc_params_c);
                        lfc_xoff_sent <= lfc_xoff_c;
                    end else if (pfc_go_c) begin
                        state         <= PFC_TX;
                        mcf_valid     <= 1'b1;
                        mcf_eth_dst   <= cfg_mcf_eth_dst;
                        mcf_eth_src   <= cfg_mcf_eth_src;
                        mcf_eth_type  <= cfg_mcf_eth_type;
                        mcf_opcode    <= cfg_tx_pfc_opcode;
                        mcf_params    <= PW'(pfc_params_c);
                        pfc_sel       <= pfc_pend;
                        pfc_xoff_sent <= pfc_xoff_c;
                    end
                end
                LFC_TX: begin
                    if (accept_c) begin
                        state            <= IDLE;
                        mcf_valid        <= 1'b0;
                        stat_tx_lfc_pkt  <= 1'b1;
                        stat_tx_lfc_xoff <= lfc_xoff_sent;
                        stat_tx_lfc_xon  <= !lfc_xoff_sent;
                    end
                end
                PFC_TX: begin
                    if (accept_c) begin
                        state            <= IDLE;
                        mcf_valid        <= 1'b0;
                        stat_tx_pfc_pkt  <= 1'b1;
                        stat_tx_pfc_xoff <= pfc_sel & pfc_xoff_sent;
                        stat_tx_pfc_xon  <= pfc_sel & ~pfc_xoff_sent;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mcf_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pause_ctrl_tx_sched.sv
// Directed bench for the transmit pause scheduler: reset, launch latency,
// LFC XOFF/XON, refresh spacing, multi-class PFC, LFC priority with
// back-pressure, cfg disable and reset during an outstanding frame.
module tb_mac_pause_ctrl_tx_sched;

    localparam int unsigned PSZ = 18;
    localparam int unsigned PW  = PSZ * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_lfc_en, tx_lfc_req;
    logic [7:0]    tx_pfc_en, tx_pfc_req;
    logic          mcf_valid, mcf_ready;
    logic [47:0]   mcf_eth_dst, mcf_eth_src;
    logic [15:0]   mcf_eth_type, mcf_opcode;
    logic [PW-1:0] mcf_params;
    logic [47:0]   cfg_mcf_eth_dst, cfg_mcf_eth_src;
    logic [15:0]   cfg_mcf_eth_type;
    logic [15:0]   cfg_tx_lfc_opcode, cfg_tx_lfc_quanta, cfg_tx_lfc_refresh;
    logic          cfg_tx_lfc_en;
    logic [15:0]   cfg_tx_pfc_opcode, cfg_tx_pfc_quanta, cfg_tx_pfc_refresh;
    logic          cfg_tx_pfc_en;
    logic [9:0]    cfg_quanta_step;
    logic          cfg_quanta_clk_en;
    logic          stat_tx_lfc_pkt, stat_tx_lfc_xon, stat_tx_lfc_xoff, stat_tx_pfc_pkt;
    logic [7:0]    stat_tx_pfc_xon, stat_tx_pfc_xoff;

    mac_pause_ctrl_tx_sched #(.MCF_PARAMS_SIZE(PSZ), .PFC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_lfc_en(tx_lfc_en), .tx_lfc_req(tx_lfc_req),
        .tx_pfc_en(tx_pfc_en), .tx_pfc_req(tx_pfc_req),
        .mcf_valid(mcf_valid), .mcf_ready(mcf_ready),
        .mcf_eth_dst(mcf_eth_dst), .mcf_eth_src(mcf_eth_src),
        .mcf_eth_type(mcf_eth_type), .mcf_opcode(mcf_opcode), .mcf_params(mcf_params),
        .cfg_mcf_eth_dst(cfg_mcf_eth_dst), .cfg_mcf_eth_src(cfg_mcf_eth_src),
        .cfg_mcf_eth_type(cfg_mcf_eth_type),
        .cfg_tx_lfc_opcode(cfg_tx_lfc_opcode), .cfg_tx_lfc_en(cfg_tx_lfc_en),
        .cfg_tx_lfc_quanta(cfg_tx_lfc_quanta), .cfg_tx_lfc_refresh(cfg_tx_lfc_refresh),
        .cfg_tx_pfc_opcode(cfg_tx_pfc_opcode), .cfg_tx_pfc_en(cfg_tx_pfc_en),
        .cfg_tx_pfc_quanta(cfg_tx_pfc_quanta), .cfg_tx_pfc_refresh(cfg_tx_pfc_refresh),
        .cfg_quanta_step(cfg_quanta_step), .cfg_quanta_clk_en(cfg_quanta_clk_en),
        .stat_tx_lfc_pkt(stat_tx_lfc_pkt), .stat_tx_lfc_xon(stat_tx_lfc_xon),
        .stat_tx_lfc_xoff(stat_tx_lfc_xoff), .stat_tx_pfc_pkt(stat_tx_pfc_pkt),
        .stat_tx_pfc_xon(stat_tx_pfc_xon), .stat_tx_pfc_xoff(stat_tx_pfc_xoff)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {lfc_pkt, lfc_xon, lfc_xoff, pfc_pkt, pfc_xon[7:0], pfc_xoff[7:0]}
    logic [19:0] stats;
    assign stats = {stat_tx_lfc_pkt, stat_tx_lfc_xon, stat_tx_lfc_xoff,
                    stat_tx_pfc_pkt, stat_tx_pfc_xon, stat_tx_pfc_xoff};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] lfc_p(input logic [15:0] q);
        logic [PW-1:0] p;
        p        = '0;
        p[7:0]   = q[15:8];
        p[15:8]  = q[7:0];
        return p;
    endfunction

    function automatic logic [PW-1:0] pfc_p(input logic [7:0] sel, input logic [7:0] on, input logic [15:0] q);
        logic [PW-1:0] p;
        p       = '0;
        p[15:8] = sel;
        for (int k = 0; k < 8; k++) begin
            if (on[k]) begin
                p[16 + 16 * k +: 8]     = q[15:8];
                p[16 + 16 * k + 8 +: 8] = q[7:0];
            end
        end
        return p;
    endfunction

    function automatic logic [19:0] st(input logic lx, input logic ln, input logic [7:0] px, input logic [7:0] pn);
        return {lx | ln, ln, lx, |(px | pn), pn, px};
    endfunction

    task automatic wait_valid(input string tag, input int max_cyc, output int t);
        t = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mcf_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({tag, "_timeout"}, 160'(mcf_valid), 160'(1'b1));
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] op, input logic [PW-1:0] params,
                                input logic [19:0] exp_stats);
        int t;
        mcf_ready = 1'b1;
        wait_valid(tag, 60, t);
        check({tag, "_op"}, 160'(mcf_opcode), 160'(op));
        check({tag, "_params"}, 160'(mcf_params), 160'(params));
        @(negedge clk);
        check({tag, "_valid_drop"}, 160'(mcf_valid), 160'(1'b0));
        check({tag, "_stats"}, 160'(stats), 160'(exp_stats));
        @(negedge clk);
        check({tag, "_stats_clr"}, 160'(stats), 160'(20'h0));
    endtask

    task automatic count_activity(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mcf_valid || (stats != 20'h0)) hits++;
        end
    endtask

    initial begin
        int t0, t1, t2, hits;
        logic          stable;
        logic [PW-1:0] snap_p;
        logic [15:0]   snap_op;

        rst_n              = 1'b0;
        tx_lfc_en          = 1'b1;
        tx_lfc_req         = 1'b1;
        tx_pfc_en          = 8'h00;
        tx_pfc_req         = 8'h00;
        mcf_ready          = 1'b1;
        cfg_mcf_eth_dst    = 48'h0180_C200_0001;
        cfg_mcf_eth_src    = 48'h0200_0000_00A5;
        cfg_mcf_eth_type   = 16'h8808;
        cfg_tx_lfc_opcode  = 16'h0001;
        cfg_tx_lfc_en      = 1'b1;
        cfg_tx_lfc_quanta  = 16'hFFFF;
        cfg_tx_lfc_refresh = 16'd0;
        cfg_tx_pfc_opcode  = 16'h0101;
        cfg_tx_pfc_en      = 1'b1;
        cfg_tx_pfc_quanta  = 16'h0040;
        cfg_tx_pfc_refresh = 16'd0;
        cfg_quanta_step    = 10'h100;
        cfg_quanta_clk_en  = 1'b1;

        // Reset values, then the first LFC frame with exact launch latency
        repeat (3) @(negedge clk);
        check("rst_valid", 160'(mcf_valid), 160'(1'b0));
        check("rst_stats", 160'(stats), 160'(20'h0));
        check("rst_params", 160'(mcf_params), 160'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("lat_e1_valid", 160'(mcf_valid), 160'(1'b0));
        @(negedge clk);
        check("lat_e2_valid", 160'(mcf_valid), 160'(1'b1));
        check("first_op", 160'(mcf_opcode), 160'(16'h0001));
        check("first_params", 160'(mcf_params), 160'(lfc_p(16'hFFFF)));
        check("first_dst", 160'(mcf_eth_dst), 160'(48'h0180_C200_0001));
        check("first_src", 160'(mcf_eth_src), 160'(48'h0200_0000_00A5));
        check("first_type", 160'(mcf_eth_type), 160'(16'h8808));
        @(negedge clk);
        check("first_stats", 160'(stats), 160'(st(1'b1, 1'b0, 8'h00, 8'h00)));
        @(negedge clk);
        check("first_stats_clr", 160'(stats), 160'(20'h0));

        // Request held, refresh disabled: nothing further
        count_activity(30, hits);
        check("no_refresh_idle", 160'(hits), 160'(0));

        // LFC XON, then XOFF with swapped quanta, then XON again
        tx_lfc_req = 1'b0;
        expect_frame("lfc_xon0", 16'h0001, lfc_p(16'h0000), st(1'b0, 1'b1, 8'h00, 8'h00));
        cfg_tx_lfc_quanta = 16'h1234;
        tx_lfc_req = 1'b1;
        expect_frame("lfc_xoff", 16'h0001, lfc_p(16'h1234), st(1'b1, 1'b0, 8'h00, 8'h00));
        tx_lfc_req = 1'b0;
        expect_frame("lfc_xon", 16'h0001, lfc_p(16'h0000), st(1'b0, 1'b1, 8'h00, 8'h00));

        // Refresh every 10 quanta at one quanta per clock
        cfg_tx_lfc_refresh = 16'd10;
        tx_lfc_req = 1'b1;
        wait_valid("ref0", 40, t0);
        wait_valid("ref1", 40, t1);
        wait_valid("ref2", 40, t2);
        cfg_tx_lfc_refresh = 16'd0;
        check("refresh_gap1", 160'((t1 - t0 >= 11) && (t1 - t0 <= 13)), 160'(1'b1));
        check("refresh_gap2", 160'((t2 - t1 >= 11) && (t2 - t1 <= 13)), 160'(1'b1));
        check("refresh_params", 160'(mcf_params), 160'(lfc_p(16'h1234)));
        @(negedge clk);
        @(negedge clk);
        count_activity(40, hits);
        check("refresh_off_idle", 160'(hits), 160'(0));
        tx_lfc_req = 1'b0;
        expect_frame("lfc_xon_ref", 16'h0001, lfc_p(16'h0000), st(1'b0, 1'b1, 8'h00, 8'h00));

        // Two PFC classes rising together share one frame
        tx_pfc_en  = 8'hFF;
        tx_pfc_req = 8'h24;
        expect_frame("pfc_xoff", 16'h0101, pfc_p(8'h24, 8'h24, 16'h0040), st(1'b0, 1'b0, 8'h24, 8'h00));
        tx_pfc_req = 8'h00;
        expect_frame("pfc_xon", 16'h0101, pfc_p(8'h24, 8'h00, 16'h0040), st(1'b0, 1'b0, 8'h00, 8'h24));

        // LFC transmit disabled: request changes are dropped
        cfg_tx_lfc_en = 1'b0;
        tx_lfc_req = 1'b1;
        count_activity(20, hits);
        check("lfc_cfg_off", 160'(hits), 160'(0));
        tx_lfc_req = 1'b0;
        repeat (3) @(negedge clk);
        cfg_tx_lfc_en = 1'b1;
        count_activity(10, hits);
        check("lfc_cfg_on_quiet", 160'(hits), 160'(0));

        // LFC beats PFC; fields hold under back-pressure; PFC follows
        mcf_ready  = 1'b0;
        tx_lfc_req = 1'b1;
        tx_pfc_req = 8'h01;
        wait_valid("prio", 40, t0);
        check("prio_op", 160'(mcf_opcode), 160'(16'h0001));
        check("prio_params", 160'(mcf_params), 160'(lfc_p(16'h1234)));
        snap_p  = mcf_params;
        snap_op = mcf_opcode;
        stable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mcf_valid || mcf_params != snap_p || mcf_opcode != snap_op || stats != 20'h0) stable = 1'b0;
        end
        check("prio_stable", 160'(stable), 160'(1'b1));
        mcf_ready = 1'b1;
        @(negedge clk);
        check("prio_accept_valid", 160'(mcf_valid), 160'(1'b0));
        check("prio_accept_stats", 160'(stats), 160'(st(1'b1, 1'b0, 8'h00, 8'h00)));
        expect_frame("pfc_after_lfc", 16'h0101, pfc_p(8'h01, 8'h01, 16'h0040), st(1'b0, 1'b0, 8'h01, 8'h00));

        // Reset while a frame is outstanding, with a PFC frame still pending
        mcf_ready  = 1'b0;
        tx_lfc_req = 1'b0;
        tx_pfc_req = 8'h00;
        wait_valid("rst_mid", 40, t0);
        check("rst_mid_pre_valid", 160'(mcf_valid), 160'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 160'(mcf_valid), 160'(1'b0));
        check("rst_mid_stats", 160'(stats), 160'(20'h0));
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mcf_ready = 1'b1;
        count_activity(30, hits);
        check("rst_mid_no_retry", 160'(hits), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_pause_ctrl_tx_sched.md
Name: mac_pause_ctrl_tx_sched

Overview:
Transmit-side pause scheduler. It converts local congestion requests (LFC and per-class PFC) into MAC control frame (MCF) requests for the TX MAC control frame generator. It sends XOFF on request assertion, XON on release, and periodic refresh XOFFs while a request stays asserted. It is a single-outstanding-frame sequencer on one clock domain, placed between the local flow-control logic and the TX MCF insertion path.

Parameters:
MCF_PARAMS_SIZE, 18, MCF parameter field width in bytes; must be >=18 if PFC_EN, else >=2 (elaboration-time fatal otherwise)
PFC_EN, 1'b1, enables PFC frame generation; when 0, PFC logic is tied off and outputs are 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tx_lfc_en  in  1  LFC enable from the MAC
tx_lfc_req  in  1  local LFC pause request
tx_pfc_en  in  8  per-class PFC enable
tx_pfc_req  in  8  per-class local PFC pause request
mcf_valid  out  1  MCF request valid
mcf_ready  in  1  MCF accepted by the generator
mcf_eth_dst  out  48  frame destination MAC
mcf_eth_src  out  48  frame source MAC
mcf_eth_type  out  16  frame EtherType
mcf_opcode  out  16  frame opcode
mcf_params  out  MCF_PARAMS_SIZE*8  frame parameters; byte 0 in bits [7:0]
cfg_mcf_eth_dst / cfg_mcf_eth_src / cfg_mcf_eth_type  in  48/48/16  header fields, copied into each frame
cfg_tx_lfc_opcode  in  16  LFC opcode (normally 0x0001)
cfg_tx_lfc_en  in  1  LFC transmit enable
cfg_tx_lfc_quanta  in  16  XOFF quanta for LFC
cfg_tx_lfc_refresh  in  16  LFC refresh interval in quanta; 0 disables refresh
cfg_tx_pfc_opcode  in  16  PFC opcode (normally 0x0101)
cfg_tx_pfc_en  in  1  PFC transmit enable
cfg_tx_pfc_quanta  in  16  XOFF quanta, common to all classes
cfg_tx_pfc_refresh  in  16  PFC refresh interval in quanta; 0 disables refresh
cfg_quanta_step  in  10  quanta increment per enabled clock, 8 fractional bits
cfg_quanta_clk_en  in  1  quanta accumulator clock enable
stat_tx_lfc_pkt / stat_tx_lfc_xon / stat_tx_lfc_xoff  out  1  one-cycle pulses on LFC frame acceptance
stat_tx_pfc_pkt  out  1  pulse on PFC frame acceptance
stat_tx_pfc_xon / stat_tx_pfc_xoff  out  8  per-class pulses on PFC frame acceptance

Behaviour:
- Reset: all outputs 0, state IDLE, all pending bits, counters and edge registers 0.
- Quanta tick: 10-bit sum {inc, acc} = acc + cfg_quanta_step when cfg_quanta_clk_en is high; inc (0..3) is registered.
- Effective requests: lfc_eff = tx_lfc_req & tx_lfc_en; pfc_eff[k] = tx_pfc_req[k] & tx_pfc_en[k]. Both are registered into *_d each cycle.
- Pending set: when lfc_eff != lfc_eff_d, set lfc_pend; same per class for PFC. The pending bit sets at the same edge that registers the change.
- Refresh: each refresh counter decrements by inc, saturating at 0. When a counter is 0, eff is high, refresh cfg != 0 and the class is neither pending nor in flight, set pend. The counter reloads with the refresh cfg when an XOFF for that class is accepted.
- cfg_tx_lfc_en / cfg_tx_pfc_en low: clear the matching pending bits and never launch that frame type.
- FSM states: IDLE, LFC_TX, PFC_TX.
- IDLE -> LFC_TX if lfc_pend, else IDLE -> PFC_TX if any pfc_pend; LFC has strict priority.
- On launch, register all mcf_* fields and assert mcf_valid on the next cycle.
- Latency: eff change at edge E sets pend at E; mcf_valid rises after edge E+1.
- LFC frame: params[7:0] = Q[15:8], params[15:8] = Q[7:0]. Q = cfg_tx_lfc_quanta if lfc_eff is high at launch, else 0. Remaining bytes are 0.
- PFC frame: params[7:0] = 0; params[15:8] = snapshot of pfc_pend, which is the class-enable vector. For each class k, params[16+16k +: 16] is byte-swapped Q. Q = cfg_tx_pfc_quanta if pfc_eff[k], else 0. Non-selected classes are 0.
- Launch clears the snapshotted pending bits. A change arriving while a frame is in flight re-sets pend, so a further frame follows.
- mcf_* fields are stable while mcf_valid is high and ready is low.
- On valid & ready: return to IDLE and pulse the stats for one cycle at the next edge.
  - xoff when the sent Q != 0, xon when Q == 0.
  - PFC xon/xoff pulses apply only to selected classes.
- The earliest next launch is the cycle after acceptance, so there are no back-to-back valid cycles across frames.
- Asynchronous reset mid-frame drops mcf_valid immediately. No frame is retried.

Test Plan:
- Reset deasserts with tx_lfc_req=1, tx_lfc_en=1, cfg_tx_lfc_en=1, quanta 0xFFFF, ready=1 -> one LFC frame: opcode 0x0001, params[15:0]=0xFFFF, stat_tx_lfc_xoff pulse.
- LFC req 1 then 0, quanta 0x1234 -> XOFF params[15:0]=0x3412, then XON params 0, stat_tx_lfc_xon pulse.
- step=0x100, lfc refresh=10, req held high -> XOFF frames spaced 11-13 cycles apart; with refresh=0, only one frame.
- pfc_req[2] and pfc_req[5] rise in the same cycle, quanta 0x0040 -> single PFC frame: params[15:8]=0x24, class 2/5 quanta bytes 0x40,0x00, stat_tx_pfc_xoff=0x24.
- LFC and PFC both pending with ready held low 20 cycles -> LFC frame first with fields stable throughout; PFC frame follows after acceptance.
- rst_n asserted while mcf_valid is high -> valid 0 immediately, no stat pulse, pending cleared.
